// File: rtl/stage1_part.sv
// One lane of the CORDIC front end: from a captured float x it produces x/2, x*x
// and the Q2.20 angle (x-128)/128. CALC registers the raw terms; NORM rounds them and publishes.
module stage1_part #(
    parameter int FLT_DATA_WIDTH    = 32,
    parameter int CORDIC_DATA_WIDTH = 22
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic                         start,
    input  logic [FLT_DATA_WIDTH-1:0]    x,
    output logic [FLT_DATA_WIDTH-1:0]    half,
    output logic [FLT_DATA_WIDTH-1:0]    square,
    output logic [CORDIC_DATA_WIDTH-1:0] x_to_cordic,
    output logic                         done,
    output logic                         working
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW   = CORDIC_DATA_WIDTH;
    localparam int FRAC = CW - 2;
    // Biased exponent at which x*2^(FRAC-7) equals the integer mantissa unshifted.
    localparam int SH0  = 157 - FRAC;

    localparam logic [1:0] SQ_NORMAL = 2'd0;
    localparam logic [1:0] SQ_ZERO   = 2'd1;
    localparam logic [1:0] SQ_INF    = 2'd2;
    localparam logic [1:0] SQ_NAN    = 2'd3;

    localparam logic [CW-1:0] CORD_MAX  = {1'b0, {(CW-1){1'b1}}};
    localparam logic [CW-1:0] CORD_MIN  = {1'b1, {(CW-1){1'b0}}};
    localparam logic [CW-1:0] CORD_ZERO = {2'b11, {FRAC{1'b0}}};
    localparam logic signed [65:0] CORD_HI  = (66'sd1 <<< (CW-1)) - 66'sd1;
    localparam logic signed [65:0] CORD_LO  = -(66'sd1 <<< (CW-1));
    localparam logic signed [65:0] CORD_OFF = 66'sd1 <<< FRAC;

    state_t state_q, state_d;
    logic [31:0] x_q, x_d;
    logic        working_q, working_d;
    logic        done_q, done_d;
    logic        calc_en, norm_en;

    logic [47:0]        prod_q, prod_d;
    logic signed [10:0] sq_exp_q, sq_exp_d;
    logic [1:0]         sq_kind_q, sq_kind_d;
    logic [31:0]        half_calc_q, half_calc_d;
    logic [CW-1:0]      cord_calc_q, cord_calc_d;

    logic [31:0]   half_q, square_q, square_d;
    logic [CW-1:0] cord_q;

    logic        x_sign;
    logic [7:0]  x_exp;
    logic [22:0] x_frac;
    logic [23:0] x_mant;

    assign x_sign = x_q[31];
    assign x_exp  = x_q[30:23];
    assign x_frac = x_q[22:0];
    assign x_mant = {1'b1, x_frac};

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        working_d = working_q;
        done_d    = done_q;
        calc_en   = 1'b0;
        norm_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CALC;
                    x_d       = x;
                    working_d = 1'b1;
                end
            end
            CALC: begin
                state_d = NORM;
                calc_en = 1'b1;
            end
            NORM: begin
                state_d   = DONE;
                norm_en   = 1'b1;
                done_d    = 1'b1;
                working_d = 1'b0;
            end
            DONE: begin
                done_d = 1'b0;
                if (start) begin
                    state_d   = CALC;
                    x_d       = x;
                    working_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (x_exp == 8'hFF) begin
            half_calc_d = x_q;
        end else if (x_exp <= 8'd1) begin
            half_calc_d = {x_sign, 31'd0};
        end else begin
            half_calc_d = {x_sign, x_exp - 8'd1, x_frac};
        end

        prod_d   = {24'd0, x_mant} * {24'd0, x_mant};
        sq_exp_d = $signed({2'b00, x_exp, 1'b0}) - 11'sd127;
        if (x_exp == 8'hFF) begin
            sq_kind_d = (x_frac != 23'd0) ? SQ_NAN : SQ_INF;
        end else if (x_exp == 8'h00) begin
            sq_kind_d = SQ_ZERO;
        end else begin
            sq_kind_d = SQ_NORMAL;
        end
    end

    logic               cord_big;
    logic [63:0]        cord_mag;
    logic signed [65:0] cord_signed;
    logic signed [65:0] cord_val;

    // Shifts beyond 40 places already sit far outside the saturation window.
    always_comb begin
        cord_big = 1'b0;
        cord_mag = '0;
        if (x_exp >= 8'(SH0)) begin
            if ((x_exp - 8'(SH0)) > 8'd40) begin
                cord_big = 1'b1;
            end else begin
                cord_mag = {40'd0, x_mant} << (x_exp - 8'(SH0));
            end
        end else begin
            cord_mag = {40'd0, x_mant} >> (8'(SH0) - x_exp);
        end
        cord_signed = $signed({2'b00, cord_mag});
        cord_val    = (x_sign ? -cord_signed : cord_signed) - CORD_OFF;

        if (x_exp == 8'hFF) begin
            cord_calc_d = (x_frac != 23'd0) ? '0 : (x_sign ? CORD_MIN : CORD_MAX);
        end else if (x_exp == 8'h00) begin
            cord_calc_d = CORD_ZERO;
        end else if (cord_big) begin
            cord_calc_d = x_sign ? CORD_MIN : CORD_MAX;
        end else if (cord_val > CORD_HI) begin
            cord_calc_d = CORD_MAX;
        end else if (cord_val < CORD_LO) begin
            cord_calc_d = CORD_MIN;
        end else begin
            cord_calc_d = cord_val[CW-1:0];
        end
    end

    logic               sq_top;
    logic [22:0]        sq_frac_pre;
    logic               sq_guard, sq_sticky, sq_round;
    logic [23:0]        sq_frac_sum;
    logic signed [10:0] sq_exp_r;

    // Carry out of the rounded fraction bumps the exponent; the fraction bits are then zero.
    always_comb begin
        sq_top      = prod_q[47];
        sq_frac_pre = sq_top ? prod_q[46:24] : prod_q[45:23];
        sq_guard    = sq_top ? prod_q[23] : prod_q[22];
        sq_sticky   = sq_top ? (|prod_q[22:0]) : (|prod_q[21:0]);
        sq_round    = sq_guard & (sq_sticky | sq_frac_pre[0]);
        sq_frac_sum = {1'b0, sq_frac_pre} + {23'd0, sq_round};
        sq_exp_r    = sq_exp_q + $signed({10'd0, sq_top}) + $signed({10'd0, sq_frac_sum[23]});
        square_d    = {1'b0, sq_exp_r[7:0], sq_frac_sum[22:0]};
        case (sq_kind_q)
            SQ_NAN:  square_d = 32'h7FC0_0000;
            SQ_INF:  square_d = 32'h7F80_0000;
            SQ_ZERO: square_d = 32'h0000_0000;
            default: begin
                if (sq_exp_r > 11'sd254) begin
                    square_d = 32'h7F80_0000;
                end else if (sq_exp_r < 11'sd1) begin
                    square_d = 32'h0000_0000;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            working_q   <= 1'b0;
            done_q      <= 1'b0;
            prod_q      <= '0;
            sq_exp_q    <= '0;
            sq_kind_q   <= SQ_NORMAL;
            half_calc_q <= '0;
            cord_calc_q <= '0;
            half_q      <= '0;
            square_q    <= '0;
            cord_q      <= '0;
        end else if (clk_en) begin
            state_q   <= state_d;
            x_q       <= x_d;
            working_q <= working_d;
            done_q    <= done_d;
            if (calc_en) begin
                prod_q      <= prod_d;
                sq_exp_q    <= sq_exp_d;
                sq_kind_q   <= sq_kind_d;
                half_calc_q <= half_calc_d;
                cord_calc_q <= cord_calc_d;
            end
            if (norm_en) begin
                half_q   <= half_calc_q;
                square_q <= square_d;
                cord_q   <= cord_calc_q;
            end
        end
    end

    assign half        = half_q;
    assign square      = square_q;
    assign x_to_cordic = cord_q;
    assign done        = done_q;
    assign working     = working_q;

endmodule

// File: tb/tb_stage1_part.sv
// Bench for stage1_part: known-answer table, hand-built multi-cycle sequences and
// random operands checked against an arithmetic reference model.
module tb_stage1_part;

    typedef struct {
        logic [31:0] x;
        logic [31:0] half;
        logic [31:0] square;
        logic [21:0] cordic;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, clk_en, start;
    logic [31:0] x, half, square;
    logic [21:0] x_to_cordic;
    logic        done, working;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_op  = 0;
    int   en;
    vec_t tbl[14];
    int   en_pat[6] = '{1, 0, 0, 1, 0, 1};

    stage1_part #(
        .FLT_DATA_WIDTH   (32),
        .CORDIC_DATA_WIDTH(22)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .start      (start),
        .x          (x),
        .half       (half),
        .square     (square),
        .x_to_cordic(x_to_cordic),
        .done       (done),
        .working    (working)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic chk_res(input string tag, input vec_t v);
        chk({tag, "_half"}, half, v.half);
        chk({tag, "_square"}, square, v.square);
        chk({tag, "_cordic"}, 32'(x_to_cordic), 32'(v.cordic));
    endtask

    // Reference model: results derived from real-number meaning of the operand.
    function automatic logic [31:0] model_half(input logic [31:0] v);
        if (v[30:23] == 8'hFF) return v;
        if (v[30:23] <= 8'd1) return {v[31], 31'd0};
        return v - 32'h0080_0000;
    endfunction

    function automatic logic [31:0] model_square(input logic [31:0] v);
        int e, re, k;
        longint unsigned m, p, q, rem, tie;
        e = int'(v[30:23]);
        if (e == 255) return (v[22:0] != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
        if (e == 0) return 32'h0;
        m   = {40'd0, 1'b1, v[22:0]};
        p   = m * m;
        k   = (p >= (64'd1 << 47)) ? 24 : 23;
        q   = p >> k;
        rem = p - (q << k);
        tie = 64'd1 << (k - 1);
        if (rem > tie || (rem == tie && q[0])) q = q + 1;
        re = 2 * e - 127 + (k - 23);
        if (q == (64'd1 << 24)) begin
            q  = q >> 1;
            re = re + 1;
        end
        if (re > 254) return 32'h7F80_0000;
        if (re < 1) return 32'h0;
        return {1'b0, 8'(re), q[22:0]};
    endfunction

    function automatic logic [21:0] model_cordic(input logic [31:0] v);
        int  e;
        real mag, val;
        e = int'(v[30:23]);
        if (e == 255) return (v[22:0] != 23'd0) ? 22'h0 : (v[31] ? 22'h200000 : 22'h1FFFFF);
        if (e == 0) return 22'h300000;
        mag = real'({1'b1, v[22:0]}) * (2.0 ** (e - 137));
        val = v[31] ? -mag : mag;
        if (val - 1048576.0 >= 2097151.0) return 22'h1FFFFF;
        if (val - 1048576.0 <= -2097152.0) return 22'h200000;
        return 22'($rtoi(val) - 1048576);
    endfunction

    function automatic vec_t model(input logic [31:0] xv);
        vec_t v;
        v.x      = xv;
        v.half   = model_half(xv);
        v.square = model_square(xv);
        v.cordic = model_cordic(xv);
        return v;
    endfunction

    function automatic logic [31:0] rnd_x();
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        s = 1'($urandom);
        f = 23'($urandom);
        case ($urandom_range(0, 4))
            0: e = 8'($urandom);
            1: e = 8'($urandom_range(110, 146));
            2: e = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(253, 255));
            3: e = 8'($urandom_range(61, 65));
            default: e = 8'($urandom_range(188, 192));
        endcase
        if ($urandom_range(0, 7) == 0) f = 23'd0;
        return {s, e, f};
    endfunction

    task automatic show(input string tag);
        n_op++;
        $display("op %0d %s x=%h half=%h square=%h cordic=%h", n_op, tag, dut.x_q, half, square, x_to_cordic);
    endtask

    task automatic run_fixed(input string tag, input vec_t v);
        x = v.x; start = 1'b1; clk_en = 1'b1;
        tick();
        chk({tag, "_work_e0"}, 32'(working), 32'd1);
        chk({tag, "_done_e0"}, 32'(done), 32'd0);
        start = 1'b0; x = $urandom;
        tick();
        chk({tag, "_work_e1"}, 32'(working), 32'd1);
        chk({tag, "_done_e1"}, 32'(done), 32'd0);
        tick();
        chk({tag, "_done_e2"}, 32'(done), 32'd1);
        chk({tag, "_work_e2"}, 32'(working), 32'd0);
        chk_res(tag, v);
        show(tag);
        tick();
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk_res({tag, "_hold"}, v);
    endtask

    task automatic run_random(input logic [31:0] xv);
        vec_t v;
        int   en_cnt;
        int   cyc;
        v = model(xv);
        x = xv; start = 1'b1; clk_en = 1'b1;
        tick();
        start = 1'b0; x = $urandom;
        en_cnt = 1; cyc = 0;
        while (en_cnt < 3) begin
            chk("rnd_done_early", 32'(done), 32'd0);
            chk("rnd_working", 32'(working), 32'd1);
            clk_en = (cyc > 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
            tick();
            if (clk_en) en_cnt++;
            cyc++;
        end
        chk("rnd_done", 32'(done), 32'd1);
        chk("rnd_work_off", 32'(working), 32'd0);
        chk_res("rnd", v);
        show("rnd");
        clk_en = 1'b0;
        tick();
        chk("rnd_done_hold", 32'(done), 32'd1);
        chk_res("rnd_hold", v);
        clk_en = 1'b1;
        tick();
        chk("rnd_done_clr", 32'(done), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{32'h40400000, 32'h3FC00000, 32'h41100000, 22'h306000};
        tbl[1]  = '{32'h43000000, 32'h42800000, 32'h46800000, 22'h000000};
        tbl[2]  = '{32'h437F0000, 32'h42FF0000, 32'h477E0100, 22'h0FE000};
        tbl[3]  = '{32'h00000000, 32'h00000000, 32'h00000000, 22'h300000};
        tbl[4]  = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 22'h000000};
        tbl[5]  = '{32'h7F000000, 32'h7E800000, 32'h7F800000, 22'h1FFFFF};
        tbl[6]  = '{32'h3FC00000, 32'h3F400000, 32'h40100000, 22'h303000};
        tbl[7]  = '{32'hFF800000, 32'hFF800000, 32'h7F800000, 22'h200000};
        tbl[8]  = '{32'h00800000, 32'h00000000, 32'h00000000, 22'h300000};
        tbl[9]  = '{32'hBF000000, 32'hBE800000, 32'h3E800000, 22'h2FF000};
        tbl[10] = '{32'hC3000000, 32'hC2800000, 32'h46800000, 22'h200000};
        tbl[11] = '{32'h43C00000, 32'h43400000, 32'h48100000, 22'h1FFFFF};
        tbl[12] = '{32'h3F800800, 32'h3F000800, 32'h3F801000, 22'h302002};
        tbl[13] = '{32'h80000001, 32'h80000000, 32'h00000000, 22'h300000};

        rst = 1'b1; clk_en = 1'b0; start = 1'b0; x = '0;
        tick();
        tick();
        chk("rst_half", half, 32'd0);
        chk("rst_square", square, 32'd0);
        chk("rst_cordic", 32'(x_to_cordic), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_working", 32'(working), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_fixed($sformatf("tbl%0d", i), tbl[i]);
        end

        // clk_en gaps: done only after the third enabled edge, held through stalls
        x = tbl[6].x; start = 1'b1; en = 0;
        for (int i = 0; i < 6; i++) begin
            clk_en = (en_pat[i] != 0);
            tick();
            start = 1'b0; x = $urandom;
            if (en_pat[i] != 0) en++;
            chk("tgl_done", 32'(done), (en >= 3) ? 32'd1 : 32'd0);
            chk("tgl_working", 32'(working), (en == 1 || en == 2) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            clk_en = 1'b0;
            tick();
            chk("tgl_done_stall", 32'(done), 32'd1);
            chk_res("tgl", tbl[6]);
        end
        show("tgl");
        clk_en = 1'b1;
        tick();
        chk("tgl_done_clr", 32'(done), 32'd0);

        // start during CALC/NORM ignored, then back-to-back on the done edge
        x = tbl[0].x; start = 1'b1; clk_en = 1'b1;
        tick();
        x = tbl[1].x;
        tick();
        chk("b2b_work_e1", 32'(working), 32'd1);
        chk("b2b_done_e1", 32'(done), 32'd0);
        tick();
        chk("b2b_done_e2", 32'(done), 32'd1);
        chk_res("b2b_first", tbl[0]);
        show("b2b_first");
        x = tbl[2].x;
        tick();
        chk("b2b_done_e3", 32'(done), 32'd0);
        chk("b2b_work_e3", 32'(working), 32'd1);
        chk_res("b2b_hold_e3", tbl[0]);
        start = 1'b0; x = $urandom;
        tick();
        chk("b2b_done_e4", 32'(done), 32'd0);
        chk_res("b2b_hold_e4", tbl[0]);
        tick();
        chk("b2b_done_e5", 32'(done), 32'd1);
        chk_res("b2b_second", tbl[2]);
        show("b2b_second");
        tick();
        chk("b2b_done_clr", 32'(done), 32'd0);

        // reset during NORM, applied while clk_en is low
        x = tbl[5].x; start = 1'b1; clk_en = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1; clk_en = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_half", half, 32'd0);
        chk("abort_square", square, 32'd0);
        chk("abort_cordic", 32'(x_to_cordic), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_working", 32'(working), 32'd0);
        clk_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_idle", 32'(working), 32'd0);
        end
        run_fixed("after_abort", tbl[6]);

        for (int i = 0; i < 150; i++) begin
            run_random(rnd_x());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
